// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared types and constants for the UART receiver with byte FIFO
package uart_rx_fifo_pkg;

  localparam int unsigned DEFAULT_CLOCK_FREQ = 100_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE  = 115_200;
  localparam int unsigned BYTE_W             = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - ready/valid dequeue port between the receiver FIFO and its consumer
interface uart_rx_fifo_if;
  import uart_rx_fifo_pkg::*;

  logic              io_deq_valid;
  logic              io_deq_ready;
  logic [BYTE_W-1:0] io_deq_bits;

  modport master (output io_deq_valid, output io_deq_bits, input  io_deq_ready);
  modport slave  (input  io_deq_valid, input  io_deq_bits, output io_deq_ready);

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// rtl/uart_rx_fifo_sync_fifo.sv - show-ahead register FIFO with wrap-bit pointers
module sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [clog2(DEPTH):0]  o_count,
  output logic [WIDTH-1:0]       o_head
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_wr_en;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count = r_wr - r_rd;
  assign o_head  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_pop   = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART 8N1 receiver feeding a byte FIFO with a ready/valid dequeue port
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        io_rx,
  uart_rx_fifo_if.master              deq,
  output logic [clog2(FIFO_DEPTH):0]  io_count,
  output logic                        io_busy,
  output logic                        io_frameErr,
  output logic                        io_overrun
);

  localparam int unsigned BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W      = (clog2(BIT_CYCLES) > 0) ? clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYCLES - 1);

  logic [1:0]        r_rx_sync;
  rx_state_e         r_state;
  rx_state_e         w_state_next;
  logic [CNT_W-1:0]  r_baud_cnt;
  logic [2:0]        r_bit_idx;
  logic [BYTE_W-1:0] r_shift;
  logic              r_frame_err;
  logic              r_overrun;

  logic              w_rxs;
  logic              w_tick;
  logic              w_push;
  logic              w_frame_err;
  logic              w_busy;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [BYTE_W-1:0] w_head;
  logic [clog2(FIFO_DEPTH):0] w_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rx_sync <= 2'b11;
    else        r_rx_sync <= {r_rx_sync[0], io_rx};
  end

  assign w_rxs  = r_rx_sync[1];
  assign w_tick = (r_baud_cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (!w_rxs) w_state_next = ST_START;
      ST_START:     if (w_tick) w_state_next = w_rxs ? ST_IDLE : ST_DATA;
      ST_DATA:      if (w_tick && (r_bit_idx == 3'd7)) w_state_next = ST_STOP;
      ST_STOP:      if (w_tick) w_state_next = w_rxs ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (w_rxs) w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != ST_IDLE);
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    if (r_state == ST_STOP && w_tick) begin
      w_push      = w_rxs;
      w_frame_err = !w_rxs;
    end
  end

  // Counter reloads are keyed to the current state so they line up with the transitions above.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rxs) r_baud_cnt <= HALF_LOAD;
        end
        ST_START: begin
          if (w_tick) begin
            r_baud_cnt <= FULL_LOAD;
            r_bit_idx  <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift    <= {w_rxs, r_shift[BYTE_W-1:1]};
            r_baud_cnt <= FULL_LOAD;
            r_bit_idx  <= r_bit_idx + 3'd1;
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (!w_tick) r_baud_cnt <= r_baud_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_drop = w_push && w_full && !(deq.io_deq_ready && !w_empty);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_drop;
    end
  end

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (deq.io_deq_ready),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign deq.io_deq_valid = !w_empty;
  assign deq.io_deq_bits  = w_head;
  assign io_count         = w_count;
  assign io_busy          = w_busy;
  assign io_frameErr      = r_frame_err;
  assign io_overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue-based reference model
module tb_uart_rx_fifo;

  localparam int CLK_HZ    = 100_000_000;
  localparam int BAUD      = 3_000_000;
  localparam int DEPTH     = 16;
  localparam int BIT       = CLK_HZ / BAUD;
  // Edge (counted from the edge before the start bit) at which the stop bit is judged:
  // two synchroniser flops, one IDLE decision, half a bit, then nine whole bits.
  localparam int STOP_EDGE = 3 + BIT / 2 + 9 * BIT;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [4:0] count;
  logic       busy;
  logic       fe;
  logic       ov;

  always #5 clock = ~clock;

  uart_rx_fifo_if u_if ();

  uart_rx_fifo #(
    .CLOCK_FREQ (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_rx       (rx),
    .deq         (u_if),
    .io_count    (count),
    .io_busy     (busy),
    .io_frameErr (fe),
    .io_overrun  (ov)
  );

  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned n_fe = 0;
  int unsigned n_ov = 0;
  int unsigned busy_cycles = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  int          n_pass;
  int          n_total;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    prev_valid <= u_if.io_deq_valid;
    if (u_if.io_deq_valid && !prev_valid) rise_cyc <= cyc;
    if (u_if.io_deq_valid && u_if.io_deq_ready) got.push_back(u_if.io_deq_bits);
    if (fe)   n_fe <= n_fe + 1;
    if (ov)   n_ov <= n_ov + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BIT);
    end
    rx = stop_lvl;
    tick(BIT);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic drain_n(input int n);
    int tgt;
    tgt = got.size() + n;
    u_if.io_deq_ready = 1'b1;
    for (int i = 0; i < 4 * n + 20 && got.size() < tgt; i++) tick(1);
    u_if.io_deq_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    u_if.io_deq_ready = 1'b0;
    rx = 1'b1;
    tick(3);
    n_total++;
    if ({u_if.io_deq_valid, u_if.io_deq_bits, count, busy, fe, ov} !== 17'd0)
      $display("FAIL reset_outputs: got valid=%b bits=%h count=%0d busy=%b fe=%b ov=%b, required all 0",
               u_if.io_deq_valid, u_if.io_deq_bits, count, busy, fe, ov);
    else n_pass++;
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_basic;
    logic [7:0] bytes [2];
    int unsigned base, fe0, ov0, c0, lat;
    bytes[0] = 8'h55;
    bytes[1] = 8'hA3;
    base = got.size();
    fe0 = n_fe;
    ov0 = n_ov;
    u_if.io_deq_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      c0 = cyc;
      send_byte(bytes[k]);
      lat = rise_cyc - c0;
      n_total++;
      if (lat < 9 * BIT || 2 * lat > 19 * BIT + 6)
        $display("FAIL basic_latency[%0d]: got %0d cycles, required %0d..%0d", k, lat, 9 * BIT, (19 * BIT + 6) / 2);
      else n_pass++;
    end
    tick(4);
    u_if.io_deq_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got.size() <= base + k || got[base + k] !== bytes[k])
        $display("FAIL basic_byte[%0d]: got %h (received %0d), required %h", k,
                 (got.size() > base + k) ? got[base + k] : 8'hxx, got.size() - base, bytes[k]);
      else n_pass++;
    end
    n_total++;
    if (n_fe != fe0 || n_ov != ov0)
      $display("FAIL basic_no_errors: got fe=%0d ov=%0d pulses, required 0", n_fe - fe0, n_ov - ov0);
    else n_pass++;
  endtask

  task automatic test_glitch;
    int unsigned b0, g0, fe0;
    b0 = busy_cycles;
    g0 = got.size();
    fe0 = n_fe;
    rx = 1'b0;
    tick(BIT / 3);
    rx = 1'b1;
    tick(2 * BIT);
    n_total++;
    if (busy_cycles - b0 != BIT / 2)
      $display("FAIL glitch_busy_len: got %0d busy cycles, required %0d", busy_cycles - b0, BIT / 2);
    else n_pass++;
    n_total++;
    if (count !== 5'd0 || got.size() != g0 || n_fe != fe0 || busy !== 1'b0)
      $display("FAIL glitch_quiet: got count=%0d fe=%0d busy=%b, required count=0 fe=0 busy=0",
               count, n_fe - fe0, busy);
    else n_pass++;
  endtask

  task automatic test_frame_err;
    int unsigned fe0, g0;
    fe0 = n_fe;
    g0 = got.size();
    send_frame(8'h7E, 1'b0);
    tick(5 * BIT);
    rx = 1'b1;
    tick(BIT);
    n_total++;
    if (n_fe - fe0 != 1 || count !== 5'd0)
      $display("FAIL frame_err: got %0d pulses count=%0d, required 1 pulse count=0", n_fe - fe0, count);
    else n_pass++;
    u_if.io_deq_ready = 1'b1;
    send_byte(8'h11);
    tick(4);
    u_if.io_deq_ready = 1'b0;
    n_total++;
    if (got.size() != g0 + 1 || got[got.size() - 1] !== 8'h11)
      $display("FAIL frame_recover: got %0d bytes last=%h, required 1 byte 11", got.size() - g0,
               (got.size() > 0) ? got[got.size() - 1] : 8'hxx);
    else n_pass++;
  endtask

  task automatic compare_drain(input string name);
    int unsigned base, n;
    base = got.size();
    n = exp_q.size();
    drain_n(n);
    for (int i = 0; i < n; i++) begin
      n_total++;
      if (got.size() <= base + i || got[base + i] !== exp_q[i])
        $display("FAIL %s_drain[%0d]: got %h, required %h", name, i,
                 (got.size() > base + i) ? got[base + i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
  endtask

  task automatic test_overflow;
    int unsigned ov0, ov_exp;
    exp_q.delete();
    ov0 = n_ov;
    ov_exp = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      send_byte(8'(i));
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
      else ov_exp++;
    end
    tick(2);
    n_total++;
    if (count !== 5'(exp_q.size()) || n_ov - ov0 != ov_exp)
      $display("FAIL overflow_state: got count=%0d overruns=%0d, required count=%0d overruns=%0d",
               count, n_ov - ov0, exp_q.size(), ov_exp);
    else n_pass++;
    compare_drain("overflow");
  endtask

  task automatic test_full_pop;
    int unsigned ov0;
    logic [7:0] b, popped;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b);
      exp_q.push_back(b);
    end
    ov0 = n_ov;
    fork
      send_byte(8'h42);
      begin
        tick(STOP_EDGE - 1);
        u_if.io_deq_ready = 1'b1;
        tick(1);
        u_if.io_deq_ready = 1'b0;
      end
    join
    tick(2);
    popped = exp_q.pop_front();
    exp_q.push_back(8'h42);
    n_total++;
    if (n_ov != ov0 || count !== 5'd16)
      $display("FAIL full_pop_state: got overruns=%0d count=%0d, required overruns=0 count=16", n_ov - ov0, count);
    else n_pass++;
    n_total++;
    if (got.size() == 0 || got[got.size() - 1] !== popped)
      $display("FAIL full_pop_head: got %h, required %h", (got.size() > 0) ? got[got.size() - 1] : 8'hxx, popped);
    else n_pass++;
    compare_drain("full_pop");
  endtask

  task automatic test_random;
    logic [7:0] b;
    bit done;
    exp_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          b = 8'($urandom_range(0, 255));
          exp_q.push_back(b);
          send_byte(b);
          tick($urandom_range(0, BIT));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          u_if.io_deq_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    u_if.io_deq_ready = 1'b0;
    // Bytes already taken during the random-ready phase are matched first.
    begin
      int unsigned start, taken;
      start = got.size();
      taken = 0;
      for (int i = 0; i < got.size(); i++) ;
      taken = 8 - int'(count);
      start = got.size() - taken;
      for (int i = 0; i < taken; i++) begin
        n_total++;
        if (got[start + i] !== exp_q[0])
          $display("FAIL random_live[%0d]: got %h, required %h", i, got[start + i], exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
      end
    end
    compare_drain("random");
  endtask

  task automatic test_reset_mid;
    int unsigned g0;
    u_if.io_deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
    rx = 1'b0;
    tick(BIT / 2 + 3 * BIT);
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if (u_if.io_deq_valid !== 1'b0 || count !== 5'd0 || busy !== 1'b0)
      $display("FAIL reset_mid: got valid=%b count=%0d busy=%b, required 0 0 0", u_if.io_deq_valid, count, busy);
    else n_pass++;
    rx = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(2 * BIT);
    g0 = got.size();
    u_if.io_deq_ready = 1'b1;
    send_byte(8'hC8);
    tick(4);
    u_if.io_deq_ready = 1'b0;
    n_total++;
    if (got.size() != g0 + 1 || got[got.size() - 1] !== 8'hC8)
      $display("FAIL reset_recover: got %0d bytes last=%h, required 1 byte c8", got.size() - g0,
               (got.size() > 0) ? got[got.size() - 1] : 8'hxx);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_overflow;
    test_full_pop;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART 8N1 receiver with an output byte FIFO.
- Sits between the board RX pin and the DebugAccessPort command decoder, and runs on the PLL system clock.
- Decouples serial arrival from DAP consumption through a ready/valid dequeue port.
- Reports framing and overrun events as single-cycle pulses for LED/status use.

Parameters:
CLOCK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; BIT_CYCLES = CLOCK_FREQ/BAUD_RATE (integer division, 868 at defaults)
FIFO_DEPTH, 16, byte entries; must be a power of two and at least 2

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronised by the instantiating top
io_rx  in  1  raw UART line, idle high, asynchronous to clock
io_deq_ready  in  1  consumer accepts the head byte this cycle
io_deq_valid  out  1  FIFO non-empty
io_deq_bits  out  8  head byte (show-ahead); stable while valid && !ready
io_count  out  log2(FIFO_DEPTH)+1  current occupancy
io_busy  out  1  high while the receiver FSM is not IDLE
io_frameErr  out  1  one-cycle pulse: stop bit sampled low
io_overrun  out  1  one-cycle pulse: received byte dropped because the FIFO was full

Behaviour:
- Reset values:
  - 2-flop rx synchroniser flops = 1.
  - FSM = IDLE; baud counter = 0; bit index = 0; shift register = 0.
  - FIFO pointers = 0.
  - All outputs 0; io_deq_bits = 0.
- Reset asserted mid-frame or mid-dequeue aborts the frame and empties the FIFO. There is no partial-byte delivery.
- Sampling: only the synchronised rx (rxs) is used; input-to-decision latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rxs == 0 -> START; baud counter loads BIT_CYCLES/2 - 1.
  - START: count down to 0, then sample rxs. If 1 (glitch) -> IDLE with no error. If 0 -> DATA; counter = BIT_CYCLES-1; bit index = 0.
  - DATA: at counter 0, shift rxs in LSB first and reload the counter. After the 8th bit -> STOP.
  - STOP: at counter 0, sample rxs.
    - 1: push byte, then -> IDLE.
    - 0: pulse io_frameErr, discard byte, -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxs == 1, then -> IDLE. This covers a break or a stuck-low line, and io_frameErr fires once per event.
- io_busy = (state != IDLE).
- Push:
  - Occurs in the stop-sample cycle.
  - io_deq_valid rises the following cycle if the FIFO was empty.
  - If the FIFO is full and no pop occurs that cycle, pulse io_overrun and drop the new byte. Stored data is untouched.
- Pop: io_deq_valid && io_deq_ready at a rising edge advances the read pointer. Ready while empty has no effect.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - When full, the pop frees space, so the push is accepted and there is no overrun.
  - When empty, the new byte appears next cycle. There is no same-cycle bypass.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - full = MSBs differ and LSBs equal; empty = pointers equal.
  - io_count = wr - rd (modulo arithmetic).
- Storage is a register array with no reset requirement on contents. io_deq_bits reads mem[rd] when valid, else 0.

Decomposition:
- Shared package holds:
  - UART FSM state encoding (IDLE=0 .. WAIT_IDLE=4).
  - Default CLOCK_FREQ/BAUD_RATE constants.
  - Byte width 8.
  - The clog2 helper.
- One sub-module, sync_fifo, is natural. It owns:
  - Generic WIDTH/DEPTH.
  - push/pop/full/empty/count.
  - Same clock and active-low async reset.
- The receiver FSM and the synchroniser stay in uart_rx_fifo.

Test Plan:
- Send 0x55 then 0xA3 at 115200 baud, consumer ready=1 -> deq fires twice with bits 0x55, 0xA3. Each valid rises within 9.5 bit times + 3 cycles of the start edge. No error pulses.
- 300-cycle low glitch on an idle line -> FSM returns to IDLE; no byte, no io_frameErr; io_busy high for ~434 cycles only.
- Frame 0x7E with stop bit forced low, then line held low 5 bit times, then released -> exactly one io_frameErr pulse; FIFO count 0. The next valid frame 0x11 is received correctly.
- ready=0, send 17 bytes 0x00..0x10 -> count saturates at 16. One io_overrun pulse on the 17th byte. Draining yields 0x00..0x0F in order.
- With FIFO full, assert ready in the stop-sample cycle of a 0x42 frame -> no overrun; count stays 16; 0x42 is the last byte drained.
- Pull reset low mid-DATA with 3 bytes queued -> next cycle valid=0, count=0, busy=0. After release, a byte 0xC8 is received normally.
